hs_dest_rx: RTL

Destination-side receiver for the multi-bit request/acknowledge clock-domain-crossing handshake. It synchronises the incoming `request` into `clk_d` and captures a `WIDTH`-bit data bus that the source holds stable. It then runs a full four-phase acknowledge and presents the word downstream through a valid/ready register slice. It replaces the single-bit destination controller on wide CDC paths and adds a transfer counter.

---
 rtl/hs_dest_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hs_dest_rx.sv
// -----------------------------------------------------------------------------
// hs_dest_rx
// Destination side of a multi-bit four-phase request/acknowledge CDC handshake.
// The asynchronous `request` is synchronised into clk_d. The quasi-static
// source bus `d_in` is captured once per request and presented downstream
// through a one-entry valid/ready register slice. A wrapping counter records
// the number of captured words.
//
// Optional feature: define HS_DEST_RX_PARITY_EN to add even-parity checking.
// This adds input d_par and output par_err.
//
// Ports:
//   clk_d      in   destination clock
//   rst_n      in   asynchronous active-low reset
//   request    in   source request level (asynchronous to clk_d)
//   d_in       in   source data, stable while request is high
//   d_par      in   even parity over d_in    (HS_DEST_RX_PARITY_EN only)
//   par_err    out  parity mismatch on last capture (HS_DEST_RX_PARITY_EN only)
//   ack        out  registered acknowledge back to the source
//   data_out   out  captured word
//   out_valid  out  data_out holds an unconsumed word
//   out_ready  in   downstream accepts the word when out_valid is high
//   busy       out  FSM is in the ACK state
//   xfer_cnt   out  words captured since reset, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module hs_dest_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_d,
    input  logic                 rst_n,
    input  logic                 request,
    input  logic [WIDTH-1:0]     d_in,
`ifdef HS_DEST_RX_PARITY_EN
    input  logic                 d_par,
    output logic                 par_err,
`endif
    output logic                 ack,
    output logic [WIDTH-1:0]     data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   ack_q, ack_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   capture;

    assign req_s = sync_q[SYNC_STAGES-1];

    // Request synchroniser. d_in is deliberately not synchronised. It is
    // only sampled once req_s is high, and by then the source has held it
    // stable for at least SYNC_STAGES clk_d edges.
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], request};
        end
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                // Capture only when the slot is empty or draining this cycle.
                // Otherwise ack stays low, which backpressures the source.
                if (req_s && (!valid_q || out_ready)) begin
                    capture = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                // Wait for req_s to return low. This guarantees that a
                // request held high produces exactly one capture.
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase

        // A capture takes priority over a drain on the same cycle, so the
        // slot stays full with the new word and no bubble appears.
        if (capture) begin
            data_d  = d_in;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef HS_DEST_RX_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (capture) begin
            par_d = ((^d_in) != d_par);
        end
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_err = par_q;
`endif

    assign ack       = ack_q;
    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == ACK);
    assign xfer_cnt  = cnt_q;

endmodule
